// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared FSM states and constants for the I2C memory target
package i2c_target_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;
    localparam logic [6:0] DefaultAddr = 7'h50;
    localparam int BitCntW = 4;
endpackage

// File: rtl/i2c_target_sync.sv
// i2c_target_sync: bus synchronisers with START/STOP and SCL edge detection
module i2c_target_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_scl_rise,
    output logic o_scl_fall
);
    logic [2:0] r_scl, r_sda;

    // two synchroniser stages plus one history stage per line; idle bus is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end

    assign o_sda      = r_sda[1];
    assign o_scl_rise = r_scl[1] & ~r_scl[2];
    assign o_scl_fall = ~r_scl[1] & r_scl[2];
    assign o_start    = r_scl[2] & r_scl[1] & r_sda[2] & ~r_sda[1];
    assign o_stop     = r_scl[2] & r_scl[1] & ~r_sda[2] & r_sda[1];
endmodule

// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target with pointer-addressed byte memory; I2C_TARGET_MEM_WP_EN write-protects the upper half
module i2c_target_mem
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TargetAddr = DefaultAddr,
    parameter int         MemDepth   = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o
);
    localparam int AW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

    logic               w_sda, w_start, w_stop, w_rise, w_fall;
    logic               w_last, w_match, w_wp, w_mem_we;
    state_t             r_state, w_state_nxt;
    logic [BitCntW-1:0] r_cnt;
    logic [7:0]         r_shift;
    logic [AW-1:0]      r_ptr;
    logic               r_ack, r_busy;
    logic [7:0]         r_mem [MemDepth];

    i2c_target_sync u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall)
    );

    assign w_last   = r_cnt == BitCntW'(8);
    assign w_match  = r_shift[7:1] == TargetAddr;
`ifdef I2C_TARGET_MEM_WP_EN
    assign w_wp     = r_ptr[AW-1];
`else
    assign w_wp     = 1'b0;
`endif
    assign w_mem_we = w_fall && r_state == WDATA && w_last && !w_wp;
    assign busy_o   = r_busy;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // bus conditions win over bit activity; byte/ACK phases advance on SCL falls
    always_comb begin
        w_state_nxt = r_state;
        sda_oe_o    = (r_state == ADDR_ACK) || (r_state == PTR_ACK) || (r_state == WDATA_ACK) ||
                      (r_state == RDATA && !r_shift[7]);
        if (w_start) w_state_nxt = ADDR;
        else if (w_stop) w_state_nxt = IDLE;
        else if (w_fall) begin
            case (r_state)
                ADDR:      w_state_nxt = !w_last ? ADDR : (w_match ? ADDR_ACK : WAIT_STOP);
                ADDR_ACK:  w_state_nxt = r_shift[0] ? RDATA : PTR;
                PTR:       w_state_nxt = w_last ? PTR_ACK : PTR;
                PTR_ACK:   w_state_nxt = WDATA;
                WDATA:     w_state_nxt = w_last ? WDATA_ACK : WDATA;
                WDATA_ACK: w_state_nxt = WDATA;
                RDATA:     w_state_nxt = w_last ? RDATA_ACK : RDATA;
                RDATA_ACK: w_state_nxt = r_ack ? RDATA : WAIT_STOP;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // bit counter, shifter and pointer; partial bytes are dropped on START/STOP
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_ptr   <= '0;
            r_ack   <= 1'b0;
        end else if (w_start || w_stop) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            case (r_state)
                ADDR, PTR, WDATA: begin
                    r_shift <= {r_shift[6:0], w_sda};
                    r_cnt   <= r_cnt + 1'b1;
                end
                RDATA:     r_cnt <= r_cnt + 1'b1;
                RDATA_ACK: r_ack <= !w_sda;
                default:   ;
            endcase
        end else if (w_fall) begin
            case (r_state)
                ADDR_ACK: begin
                    r_cnt   <= '0;
                    r_shift <= r_shift[0] ? r_mem[r_ptr] : r_shift;
                end
                PTR:                r_ptr <= w_last ? r_shift[AW-1:0] : r_ptr;
                PTR_ACK, WDATA_ACK: r_cnt <= '0;
                WDATA:              r_ptr <= w_last ? r_ptr + 1'b1 : r_ptr;
                RDATA: begin
                    r_ptr   <= w_last ? r_ptr + 1'b1 : r_ptr;
                    r_shift <= w_last ? r_shift : {r_shift[6:0], 1'b0};
                end
                RDATA_ACK: begin
                    r_cnt   <= '0;
                    r_shift <= r_ack ? r_mem[r_ptr] : r_shift;
                end
                default: ;
            endcase
        end
    end

    // busy from an address-matched START until STOP
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                        r_busy <= 1'b0;
        else if (w_stop)                                    r_busy <= 1'b0;
        else if (r_state == ADDR && w_state_nxt == ADDR_ACK) r_busy <= 1'b1;
    end

    // byte storage, erased to 0xFF on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemDepth; i++) r_mem[i] <= 8'hFF;
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= r_shift;
        end
    end
endmodule

// File: tb/tb_i2c_target_mem.sv
// tb_i2c_target_mem: bit-banged I2C controller against a byte-array model of the target
module tb_i2c_target_mem;
    localparam int Q = 5;
`ifdef I2C_TARGET_MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic scl_c = 1'b1;
    logic sda_c = 1'b1;
    logic sda_oe_o, busy_o;
    wire  sda = sda_c & ~sda_oe_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl_mem [256];
    int mdl_ptr;

    always #5 clk = ~clk;

    i2c_target_mem dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .scl_i    (scl_c),
        .sda_i    (sda),
        .sda_oe_o (sda_oe_o),
        .busy_o   (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hFF;
        mdl_ptr = 0;
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        sda_c = b; wq();
        scl_c = 1'b1; wq(); wq();
        scl_c = 1'b0; wq();
    endtask

    task automatic rbit(output logic b);
        sda_c = 1'b1; wq();
        scl_c = 1'b1; wq();
        b = sda; wq();
        scl_c = 1'b0; wq();
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; wq();
        scl_c = 1'b1; wq();
        sda_c = 1'b0; wq();
        scl_c = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wq();
        scl_c = 1'b1; wq();
        sda_c = 1'b1; wq();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = !b;
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(!ack);
    endtask

    task automatic tx_ptr(input logic [7:0] p);
        logic a;
        i2c_start();
        wbyte(8'hA0, a);
        check("w_addr_ack", a, 1);
        wbyte(p, a);
        check("ptr_ack", a, 1);
        mdl_ptr = p;
    endtask

    task automatic tx_wr(input logic [7:0] d);
        logic a;
        wbyte(d, a);
        check("wr_ack", a, 1);
        if (!(WP && mdl_ptr >= 128)) mdl_mem[mdl_ptr] = d;
        mdl_ptr = (mdl_ptr + 1) % 256;
    endtask

    task automatic tx_rd(input int n);
        logic a;
        logic [7:0] d;
        i2c_start();
        wbyte(8'hA1, a);
        check("r_addr_ack", a, 1);
        check("busy_rd", busy_o, 1);
        for (int k = 0; k < n; k++) begin
            rbyte(k < n - 1, d);
            check("rd_data", d, mdl_mem[mdl_ptr]);
            mdl_ptr = (mdl_ptr + 1) % 256;
        end
        check("nack_release", sda_oe_o, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic a;
        logic [7:0] a0 = 8'hA0;
        mdl_reset();
        repeat (3) @(negedge clk);
        check("rst_oe", sda_oe_o, 0);
        check("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        wq();

        // fresh memory reads back erased
        tx_rd(1);
        i2c_stop();
        check("busy_after_stop", busy_o, 0);

        // write two bytes, then set pointer and read them back
        tx_ptr(8'h10); tx_wr(8'hA5); tx_wr(8'h3C); i2c_stop();
        tx_ptr(8'h10); tx_rd(2); i2c_stop();

        // foreign address is ignored entirely
        i2c_start();
        wbyte(8'hA2, a);
        check("foreign_addr_ack", a, 0);
        check("foreign_busy", busy_o, 0);
        wbyte(8'h33, a);
        check("foreign_data_ack", a, 0);
        i2c_stop();
        tx_rd(1); i2c_stop();

        // pointer wrap on write and on read
        tx_ptr(8'hFF); tx_wr(8'h11); tx_wr(8'h22); i2c_stop();
        tx_ptr(8'hFF); tx_rd(2); i2c_stop();

        // NACK then repeated START continues at the next location
        tx_ptr(8'h20); tx_wr(8'h5A); tx_wr(8'h6B); i2c_stop();
        tx_ptr(8'h20); tx_rd(1); tx_rd(1); i2c_stop();

        // upper-half write (protected when the option is built in)
        tx_ptr(8'h90); tx_wr(8'h77); i2c_stop();
        tx_ptr(8'h90); tx_rd(1); i2c_stop();

        // STOP mid-byte leaves memory and pointer untouched
        tx_ptr(8'h40);
        wbit(1'b0); wbit(1'b1); wbit(1'b1);
        i2c_stop();
        tx_rd(1); i2c_stop();

        // randomized transactions
        for (int t = 0; t < 16; t++) begin
            int op = $urandom_range(0, 2);
            int n = $urandom_range(1, 3);
            logic [7:0] p = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            if (op == 0) begin
                tx_ptr(p);
                for (int k = 0; k < n; k++) tx_wr(8'($urandom));
            end else if (op == 1) begin
                tx_rd(n);
            end else begin
                tx_ptr(p);
                tx_rd(n);
            end
            i2c_stop();
        end

        // reset while the target is driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(a0[i]);
        sda_c = 1'b1;
        wq();
        check("ack_driven", sda_oe_o, 1);
        #2 rst_ni = 1'b0;
        #1 check("async_rst_oe", sda_oe_o, 0);
        check("async_rst_busy", busy_o, 0);
        scl_c = 1'b1;
        sda_c = 1'b1;
        mdl_reset();
        wq();
        rst_ni = 1'b1;
        wq();
        tx_rd(1); i2c_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
